bird_draw: RTL and testbench
============================

BIRD_DRAW -- requirements
Module: bird_draw

Interface
REQ-001 Parameter BIRD_X, default 8'd20, fixed screen column of the bird's left edge.
REQ-002 Parameter BIRD_COLOUR, default 3'b010 (green), colour used for drawing the bird.
REQ-003 Parameter Y_MAX, default 7'd119, last visible screen row.
REQ-004 clk  input  1  system clock; single clock domain.
REQ-005 resetn  input  1  reset, asynchronous, active-low.
REQ-006 frame_tick  input  1  one-cycle pulse marking a new frame.
REQ-007 bird_y  input  7  bird top-row position from the bird control FSM; sampled only on an accepted frame_tick.
REQ-008 busy  output  1  high while an erase/draw sequence is in progress.
REQ-009 x  output  8  pixel column to the VGA adapter.
REQ-010 y  output  7  pixel row to the VGA adapter.
REQ-011 colour  output  3  pixel colour to the VGA adapter.
REQ-012 plot  output  1  write-enable to the VGA adapter; one pixel per cycle while high.

Function
REQ-013 All outputs shall be registered.
REQ-014 FSM states: IDLE, ERASE, DRAW, with a 4-bit pixel counter cnt and registers old_y[6:0], new_y[6:0] and old_valid.
REQ-015 IDLE: on frame_tick, latch new_y = min(bird_y, Y_MAX-3) (clamp keeps the 4x4 sprite on screen; y arithmetic never wraps).
REQ-016 IDLE -> ERASE on frame_tick when old_valid=1 and clamped new_y != old_y, with cnt cleared.
REQ-017 IDLE -> DRAW on frame_tick when old_valid=0, with cnt cleared.
REQ-018 IDLE stays in IDLE on frame_tick when old_valid=1 and clamped new_y == old_y; no pixels shall be plotted.
REQ-019 ERASE: plot=1, colour=3'b000, x=BIRD_X+cnt[3:2], y=old_y+cnt[1:0]; cnt increments each cycle; when cnt==4'hF go to DRAW with cnt cleared.
REQ-020 DRAW: plot=1, colour=BIRD_COLOUR, x=BIRD_X+cnt[3:2], y=new_y+cnt[1:0]; when cnt==4'hF, set old_y=new_y and old_valid=1, then go to IDLE.
REQ-021 Pixel order within a 4x4 block: column-major; cnt 0..3 = column 0, rows 0..3, and so on.
REQ-022 Latency: the first plot pixel shall appear on the cycle after the accepting frame_tick.
REQ-023 Full sequence duration: 32 plot cycles (erase then draw); first-draw sequence: 16 cycles.
REQ-024 busy shall be high exactly on the cycles plot is high.
REQ-025 plot shall be 0 in IDLE; x, y and colour hold their last values in IDLE.
REQ-026 frame_tick while busy=1 shall be ignored: bird_y is not sampled and no frame is queued.
REQ-027 frame_tick coinciding with the final DRAW cycle shall be ignored.
REQ-028 bird_y changes outside accepted ticks shall have no effect.

Reset
REQ-029 On resetn=0, asynchronously: state=IDLE, cnt=0, old_y=0, new_y=0, old_valid=0, x=0, y=0, colour=0, plot=0, busy=0.
REQ-030 Reset during ERASE or DRAW shall abort the sequence immediately, with no further plot pulses.
REQ-031 After a mid-operation reset, the next accepted frame_tick shall perform a draw-only sequence (old_valid=0).

Verification
REQ-032 After reset, frame_tick with bird_y=50 -> 16 plot cycles, colour=010, x cycling 20..23, y cycling 50..53 in column-major order; then busy=0, old_y=50.
REQ-033 With old_y=50, frame_tick with bird_y=46 -> 16 erase pixels at y 50..53 with colour 000, then 16 draw pixels at y 46..49 with colour 010; 32 contiguous plot cycles.
REQ-034 With old_y=46, frame_tick with bird_y=46 -> no plot, busy stays 0.
REQ-035 frame_tick with bird_y=127 -> draw at y 116..119; no pixel at y>119.
REQ-036 frame_tick pulsed on cycle 10 of a 32-cycle sequence with a different bird_y -> ignored; the sequence completes unchanged and old_y equals the originally latched value.
REQ-037 resetn asserted at draw cycle 5 -> plot=0 immediately; the next frame_tick with bird_y=30 -> draw-only 16 cycles at y 30..33.

Source files
------------

// File: rtl/bird_draw_if.sv
// Pixel-plotter bus between the bird renderer and its frame source / VGA adapter.
// The master drives frame requests; the slave returns plotted pixels.
interface bird_draw_if;
  logic       frame_tick;
  logic [6:0] bird_y;
  logic       busy;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;

  modport master (
    output frame_tick, bird_y,
    input  busy, x, y, colour, plot
  );

  modport slave (
    input  frame_tick, bird_y,
    output busy, x, y, colour, plot
  );
endinterface

// File: rtl/bird_draw.sv
// Erases the bird's previous 4x4 sprite and draws it at its new row, one pixel per cycle.
// Outputs are registered, so each state/cnt pair describes the pixel currently on the bus.
module bird_draw #(
  parameter logic [7:0] BIRD_X      = 8'd20,
  parameter logic [2:0] BIRD_COLOUR = 3'b010,
  parameter logic [6:0] Y_MAX       = 7'd119
) (
  input logic        clk,
  input logic        resetn,
  bird_draw_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StErase, StDraw} state_e;

  localparam logic [6:0] YTop = Y_MAX - 7'd3;

  state_e     state;
  logic [3:0] cnt;
  logic [6:0] old_y;
  logic [6:0] new_y;
  logic       old_valid;

  logic [3:0] cnt_nxt;
  logic [6:0] y_clamp;
  logic [7:0] x_nxt;

  always_comb begin
    cnt_nxt = cnt + 4'd1;
    y_clamp = (bus.bird_y > YTop) ? YTop : bus.bird_y;
    x_nxt   = BIRD_X + {6'd0, cnt_nxt[3:2]};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= StIdle;
      cnt        <= 4'd0;
      old_y      <= 7'd0;
      new_y      <= 7'd0;
      old_valid  <= 1'b0;
      bus.x      <= 8'd0;
      bus.y      <= 7'd0;
      bus.colour <= 3'd0;
      bus.plot   <= 1'b0;
      bus.busy   <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          // Ticks are only accepted here, so ticks while busy are dropped.
          if (bus.frame_tick) begin
            new_y <= y_clamp;
            cnt   <= 4'd0;
            if (!old_valid) begin
              state      <= StDraw;
              bus.plot   <= 1'b1;
              bus.busy   <= 1'b1;
              bus.x      <= BIRD_X;
              bus.y      <= y_clamp;
              bus.colour <= BIRD_COLOUR;
            end else if (y_clamp != old_y) begin
              state      <= StErase;
              bus.plot   <= 1'b1;
              bus.busy   <= 1'b1;
              bus.x      <= BIRD_X;
              bus.y      <= old_y;
              bus.colour <= 3'b000;
            end
          end
        end
        StErase: begin
          if (cnt == 4'hF) begin
            state      <= StDraw;
            cnt        <= 4'd0;
            bus.x      <= BIRD_X;
            bus.y      <= new_y;
            bus.colour <= BIRD_COLOUR;
          end else begin
            cnt   <= cnt_nxt;
            bus.x <= x_nxt;
            bus.y <= old_y + {5'd0, cnt_nxt[1:0]};
          end
        end
        StDraw: begin
          if (cnt == 4'hF) begin
            state     <= StIdle;
            cnt       <= 4'd0;
            old_y     <= new_y;
            old_valid <= 1'b1;
            bus.plot  <= 1'b0;
            bus.busy  <= 1'b0;
          end else begin
            cnt   <= cnt_nxt;
            bus.x <= x_nxt;
            bus.y <= new_y + {5'd0, cnt_nxt[1:0]};
          end
        end
        default: begin
          state    <= StIdle;
          bus.plot <= 1'b0;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bird_draw.sv
// Scoreboard bench for bird_draw: expected pixels are queued when a frame is requested
// and compared against every plotted pixel.
module tb_bird_draw;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  bird_draw_if bus ();

  bird_draw dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  logic [17:0] sb[$];  // {x, y, colour}
  logic [17:0] exp_px;
  int          vectors = 0;
  int          miscompares = 0;
  logic [6:0]  m_old_y;
  logic        m_valid;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_block(input logic [6:0] base, input logic [2:0] col);
    for (int i = 0; i < 16; i++) begin
      sb.push_back({8'(20 + i / 4), 7'(base + 7'(i % 4)), col});
    end
  endtask

  task automatic model_frame(input logic [6:0] by, output int n);
    logic [6:0] c;
    c = (by > 7'd116) ? 7'd116 : by;
    n = 0;
    if (!m_valid) begin
      push_block(c, 3'b010);
      n = 16;
    end else if (c != m_old_y) begin
      push_block(m_old_y, 3'b000);
      push_block(c, 3'b010);
      n = 32;
    end
    m_old_y = c;
    m_valid = 1'b1;
  endtask

  always @(negedge clk) begin
    if (resetn) begin
      check("busy_vs_plot", 32'(bus.busy), 32'(bus.plot));
      if (bus.plot) begin
        if (sb.size() == 0) begin
          check("sb_underflow", sb.size(), 1);
        end else begin
          exp_px = sb.pop_front();
          check("pixel", 32'({bus.x, bus.y, bus.colour}), 32'(exp_px));
        end
      end
    end
  end

  // glitch_at / rst_at: pixel index (1-based) at which to inject a tick or a reset; 0 = none.
  task automatic run_frame(input logic [6:0] by, input int glitch_at, input logic [6:0] gy,
                           input int rst_at);
    int n;
    int len;
    @(posedge clk); #1;
    bus.bird_y     = by;
    bus.frame_tick = 1'b1;
    model_frame(by, n);
    @(posedge clk); #1;
    bus.frame_tick = 1'b0;
    bus.bird_y     = 7'($urandom);
    check("first_pixel_latency", 32'(bus.plot), 32'(n > 0));
    len = 0;
    while (bus.plot && len < 40) begin
      len++;
      if (len == rst_at) begin
        resetn = 1'b0;
        #1;
        check("rst_plot", 32'(bus.plot), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_xyc", 32'({bus.x, bus.y, bus.colour}), 0);
        sb.delete();
        m_valid = 1'b0;
        m_old_y = 7'd0;
        @(posedge clk); #1;
        check("rst_plot_hold", 32'(bus.plot), 0);
        resetn = 1'b1;
        return;
      end
      if (len == glitch_at) begin
        bus.frame_tick = 1'b1;
        bus.bird_y     = gy;
      end
      @(posedge clk); #1;
      bus.frame_tick = 1'b0;
    end
    check("seq_len", len, n);
    check("sb_drained", sb.size(), 0);
  endtask

  task automatic idle_cycles(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge clk); #1;
      bus.bird_y = 7'($urandom);
    end
  endtask

  initial begin
    bus.frame_tick = 1'b0;
    bus.bird_y     = 7'd0;
    m_valid        = 1'b0;
    m_old_y        = 7'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_plot", 32'(bus.plot), 0);
    check("reset_busy", 32'(bus.busy), 0);
    check("reset_x", 32'(bus.x), 0);
    check("reset_y", 32'(bus.y), 0);
    check("reset_colour", 32'(bus.colour), 0);
    resetn = 1'b1;
    idle_cycles(3);

    run_frame(7'd50, 0, 7'd0, 0);    // first draw only
    run_frame(7'd46, 0, 7'd0, 0);    // erase 50..53, draw 46..49
    run_frame(7'd46, 0, 7'd0, 0);    // unchanged: nothing plotted
    run_frame(7'd127, 0, 7'd0, 0);   // clamped to 116..119
    run_frame(7'd60, 10, 7'd5, 0);   // tick mid-sequence ignored
    run_frame(7'd90, 32, 7'd10, 0);  // tick on final draw cycle ignored
    run_frame(7'd90, 0, 7'd0, 0);    // old_y must be 90
    idle_cycles(6);
    run_frame(7'd90, 0, 7'd0, 0);
    run_frame(7'd80, 0, 7'd0, 21);   // reset at draw cycle 5
    idle_cycles(2);
    run_frame(7'd30, 0, 7'd0, 0);    // draw-only after reset
    run_frame(7'd0, 0, 7'd0, 0);
    run_frame(7'd116, 0, 7'd0, 0);
    run_frame(7'd117, 0, 7'd0, 0);   // clamps to current position
    idle_cycles(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
